// File: rtl/imem_loader_pkg.sv
// Shared CPU definitions for the instruction-memory loader: state encoding,
// default parameter values and the running-checksum helper.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD   = 2'b01,
    ST_FINISH = 2'b10,
    ST_ERROR  = 2'b11
  } state_e;

  localparam logic [7:0] DEF_BASE_ADDR = 8'h00;
  localparam logic [7:0] DEF_TIMEOUT   = 8'd255;

  // Mod-256 running sum of accepted instruction bytes.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts a counted byte stream from the host,
// writes it to consecutive instruction-memory addresses and keeps the CPU
// sequencer held until a load completes successfully.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [7:0] TIMEOUT   = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] byte_len,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] checksum
);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [7:0] r_count;
  logic [7:0] r_len;
  logic [7:0] r_idle;
  logic [7:0] r_checksum;
  logic [7:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic       r_wr_en;
  logic       r_in_ready;
  logic       r_busy;
  logic       r_done;
  logic       r_err;
  logic       r_hold;

  logic       w_xfer;
  logic       w_last;
  logic       w_timeout;
  logic       w_start_ok;
  logic [8:0] w_idle_inc;

  // A latched length of 0 means 256: r_len - 1 wraps to 8'hFF, matching the final count.
  assign w_xfer     = (r_state == ST_LOAD) && in_valid;
  assign w_last     = w_xfer && (r_count == (r_len - 8'd1));
  assign w_idle_inc = {1'b0, r_idle} + 9'd1;
  // A byte arriving on the timeout cycle wins over the timeout.
  assign w_timeout  = (r_state == ST_LOAD) && !w_xfer && (w_idle_inc == {1'b0, TIMEOUT});
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_ERROR));

  // Next-state decode for the load sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_ERROR: begin
        if (start) w_state_nxt = ST_LOAD;
        else       w_state_nxt = r_state;
      end
      ST_LOAD: begin
        if (w_last)         w_state_nxt = ST_FINISH;
        else if (w_timeout) w_state_nxt = ST_ERROR;
        else                w_state_nxt = ST_LOAD;
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Registered status outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_en    <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt == ST_LOAD);
      r_busy     <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_FINISH);
      r_done     <= (w_state_nxt == ST_FINISH);
      r_wr_en    <= w_xfer;
    end
  end

  // Load datapath: byte counter, idle watchdog, write port, checksum, hold and error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= 8'd0;
      r_len      <= 8'd0;
      r_idle     <= 8'd0;
      r_checksum <= 8'd0;
      r_wr_addr  <= 8'd0;
      r_wr_data  <= 8'd0;
      r_err      <= 1'b0;
      r_hold     <= 1'b1;
    end else if (w_start_ok) begin
      r_count    <= 8'd0;
      r_len      <= byte_len;
      r_idle     <= 8'd0;
      r_checksum <= 8'd0;
      r_err      <= 1'b0;
      r_hold     <= 1'b1;
    end else if (w_xfer) begin
      r_wr_addr  <= BASE_ADDR + r_count;
      r_wr_data  <= in_data;
      r_checksum <= csum_add(r_checksum, in_data);
      r_count    <= r_count + 8'd1;
      r_idle     <= 8'd0;
      if (w_last) r_hold <= 1'b0;
      else        r_hold <= r_hold;
    end else if (r_state == ST_LOAD) begin
      r_idle <= r_idle + 8'd1;
      if (w_timeout) r_err <= 1'b1;
      else           r_err <= r_err;
    end else begin
      r_idle <= r_idle;
    end
  end

  assign in_ready = r_in_ready;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign cpu_hold = r_hold;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign checksum = r_checksum;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: two instances (base 8'h00 and 8'hFE)
// share one stimulus stream and are checked against a transaction-level model.
module tb_imem_loader;

  localparam int TMO = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] byte_len;
  logic [7:0] in_data;
  logic       in_valid;

  logic       rdy0, we0, hold0, busy0, done0, err0;
  logic [7:0] addr0, data0, cs0;
  logic       rdy1, we1, hold1, busy1, done1, err1;
  logic [7:0] addr1, data1, cs1;

  imem_loader #(.BASE_ADDR(8'h00), .TIMEOUT(8'(TMO))) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_len(byte_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0), .wr_en(we0),
    .wr_addr(addr0), .wr_data(data0), .cpu_hold(hold0), .busy(busy0),
    .done(done0), .err(err0), .checksum(cs0));

  imem_loader #(.BASE_ADDR(8'hFE), .TIMEOUT(8'(TMO))) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_len(byte_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1), .wr_en(we1),
    .wr_addr(addr1), .wr_data(data1), .cpu_hold(hold1), .busy(busy1),
    .done(done1), .err(err1), .checksum(cs1));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_we0 = 0;

  // Reference model: a load in progress, a finish pulse, a sticky error.
  bit m_load, m_fin, m_err, m_hold;
  int m_cnt, m_len, m_sum, m_idle;
  bit e_we, e_done;
  int e_idx, e_dat;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_load = 0; m_fin = 0; m_err = 0; m_hold = 1;
    m_cnt = 0; m_len = 0; m_sum = 0; m_idle = 0;
    e_we = 0; e_done = 0; e_idx = 0; e_dat = 0;
  endtask

  task automatic model_step(input bit s, input logic [7:0] l, input logic [7:0] d, input bit v);
    bit was_load = m_load;
    bit was_fin  = m_fin;
    e_we = 0; e_done = 0;
    if (was_fin) m_fin = 0;
    if (was_load) begin
      if (v) begin
        e_we = 1; e_idx = m_cnt; e_dat = int'(d);
        m_sum = (m_sum + int'(d)) % 256;
        m_cnt++; m_idle = 0;
        if (m_cnt == m_len) begin
          m_load = 0; m_fin = 1; e_done = 1; m_hold = 0;
        end
      end else begin
        m_idle++;
        if (m_idle == TMO) begin m_load = 0; m_err = 1; end
      end
    end else if (!was_fin && s) begin
      m_load = 1; m_cnt = 0; m_sum = 0; m_err = 0; m_hold = 1; m_idle = 0;
      m_len = (l == 8'd0) ? 256 : int'(l);
    end
  endtask

  task automatic check_dut(input string t, input logic rdy, input logic we, input logic [7:0] a,
                           input logic [7:0] dt, input logic bz, input logic dn, input logic er,
                           input logic hd, input logic [7:0] cs, input int base);
    chk({t, "_in_ready"}, 16'(rdy), 16'(m_load));
    chk({t, "_wr_en"},    16'(we),  16'(e_we));
    chk({t, "_busy"},     16'(bz),  16'(m_load | m_fin));
    chk({t, "_done"},     16'(dn),  16'(e_done));
    chk({t, "_err"},      16'(er),  16'(m_err));
    chk({t, "_cpu_hold"}, 16'(hd),  16'(m_hold));
    chk({t, "_checksum"}, 16'(cs),  16'(m_sum));
    if (e_we) begin
      chk({t, "_wr_addr"}, 16'(a),  16'((base + e_idx) % 256));
      chk({t, "_wr_data"}, 16'(dt), 16'(e_dat));
    end
  endtask

  task automatic compare_model(input bit with_dut0);
    if (with_dut0) check_dut("d0", rdy0, we0, addr0, data0, busy0, done0, err0, hold0, cs0, 0);
    check_dut("d1", rdy1, we1, addr1, data1, busy1, done1, err1, hold1, cs1, 254);
  endtask

  // One clock: drive after the falling edge, model on the rising edge, sample at the next falling edge.
  task automatic cyc(input bit s, input logic [7:0] l, input logic [7:0] d, input bit v);
    start = s; byte_len = l; in_data = d; in_valid = v;
    @(posedge clk);
    model_step(s, l, d, v);
    @(negedge clk);
    if (we0) n_we0++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit s; logic [7:0] l; logic [7:0] d; bit v;
    bit rdy; bit we; logic [7:0] a; logic [7:0] dt; logic [7:0] cs; bit dn; bit hold; bit busy;
  } vec_t;

  vec_t tbl[8];
  logic [7:0] fe_seq[4];

  initial begin
    tbl[0] = '{1'b1, 8'd3, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 8'd0, 8'h12, 1'b1, 1'b1, 1'b1, 8'h00, 8'h12, 8'h12, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 8'd0, 8'h34, 1'b1, 1'b1, 1'b1, 8'h01, 8'h34, 8'h46, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 8'd0, 8'h56, 1'b1, 1'b0, 1'b1, 8'h02, 8'h56, 8'h9C, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h9C, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'd1, 8'hAA, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 8'd0, 8'h77, 1'b1, 1'b0, 1'b1, 8'h00, 8'h77, 8'h77, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h77, 1'b0, 1'b0, 1'b0};
    fe_seq[0] = 8'hFE; fe_seq[1] = 8'hFF; fe_seq[2] = 8'h00; fe_seq[3] = 8'h01;

    rst_n = 1'b0; start = 1'b0; byte_len = 8'd0; in_data = 8'd0; in_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_model(1'b1);
    chk("rst_wr_addr", 16'(addr0), 16'h0000);
    chk("rst_wr_data", 16'(data0), 16'h0000);
    rst_n = 1'b1;

    // Directed table: 3-byte load at base 0, then a 1-byte load started with stray data present.
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].s, tbl[i].l, tbl[i].d, tbl[i].v);
      chk("tbl_in_ready", 16'(rdy0),  16'(tbl[i].rdy));
      chk("tbl_wr_en",    16'(we0),   16'(tbl[i].we));
      chk("tbl_checksum", 16'(cs0),   16'(tbl[i].cs));
      chk("tbl_done",     16'(done0), 16'(tbl[i].dn));
      chk("tbl_cpu_hold", 16'(hold0), 16'(tbl[i].hold));
      chk("tbl_busy",     16'(busy0), 16'(tbl[i].busy));
      if (tbl[i].we) begin
        chk("tbl_wr_addr", 16'(addr0), 16'(tbl[i].a));
        chk("tbl_wr_data", 16'(data0), 16'(tbl[i].dt));
      end
      compare_model(1'b0);
    end

    // Base 8'hFE, four bytes: address must wrap through 8'hFF to 8'h00.
    do_reset();
    cyc(1'b1, 8'd4, 8'h00, 1'b0);
    compare_model(1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 8'd0, 8'(8'h40 + k), 1'b1);
      compare_model(1'b1);
      chk("fe_wr_addr", 16'(addr1), 16'(fe_seq[k]));
    end
    chk("fe_err", 16'(err1), 16'h0000);
    cyc(1'b0, 8'd0, 8'h00, 1'b0);
    compare_model(1'b1);

    // Idle watchdog: a gap of TMO-1 then a byte is fine; a gap of TMO errors out.
    do_reset();
    cyc(1'b1, 8'd3, 8'h00, 1'b0);
    cyc(1'b0, 8'd0, 8'h11, 1'b1);
    for (int k = 0; k < TMO - 1; k++) begin cyc(1'b0, 8'd0, 8'h00, 1'b0); compare_model(1'b1); end
    cyc(1'b0, 8'd0, 8'h22, 1'b1);
    compare_model(1'b1);
    chk("tmo_edge_wr_en", 16'(we0), 16'h0001);
    chk("tmo_edge_err", 16'(err0), 16'h0000);
    for (int k = 0; k < TMO; k++) begin cyc(1'b0, 8'd0, 8'h00, 1'b0); compare_model(1'b1); end
    chk("tmo_err", 16'(err0), 16'h0001);
    chk("tmo_cpu_hold", 16'(hold0), 16'h0001);
    chk("tmo_in_ready", 16'(rdy0), 16'h0000);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 8'd0, 8'h33, 1'b1);
      compare_model(1'b1);
      chk("tmo_no_write", 16'(we0), 16'h0000);
    end
    cyc(1'b1, 8'd2, 8'h00, 1'b0);
    compare_model(1'b1);
    chk("tmo_restart_err", 16'(err0), 16'h0000);
    cyc(1'b0, 8'd0, 8'h05, 1'b1); compare_model(1'b1);
    cyc(1'b0, 8'd0, 8'h06, 1'b1); compare_model(1'b1);
    chk("tmo_restart_done", 16'(done0), 16'h0001);

    // Reset after 2 of 5 bytes: outputs drop immediately and no third write follows.
    do_reset();
    cyc(1'b1, 8'd5, 8'h00, 1'b0);
    cyc(1'b0, 8'd0, 8'hA1, 1'b1);
    cyc(1'b0, 8'd0, 8'hA2, 1'b1);
    compare_model(1'b1);
    in_valid = 1'b1; in_data = 8'hA3; rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_wr_en", 16'(we0), 16'h0000);
    chk("rst_mid_cpu_hold", 16'(hold0), 16'h0001);
    chk("rst_mid_in_ready", 16'(rdy0), 16'h0000);
    chk("rst_mid_busy", 16'(busy0), 16'h0000);
    chk("rst_mid_checksum", 16'(cs0), 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_we0 = 0;
    for (int k = 0; k < 4; k++) begin cyc(1'b0, 8'd0, 8'hA4, 1'b1); compare_model(1'b1); end
    chk("rst_mid_no_write", 16'(n_we0), 16'h0000);

    // byte_len 0 loads 256 bytes; a second start mid-load is ignored.
    do_reset();
    cyc(1'b1, 8'd0, 8'h00, 1'b0);
    n_we0 = 0;
    for (int k = 0; k < 256; k++) begin
      cyc((k == 100), 8'd5, 8'($urandom), 1'b1);
      compare_model(1'b1);
      if (k == 255) chk("len256_done", 16'(done0), 16'h0001);
      else          chk("len256_not_done", 16'(done0), 16'h0000);
    end
    chk("len256_writes", 16'(n_we0), 16'd256);
    chk("len256_last_addr", 16'(addr0), 16'h00FF);
    cyc(1'b0, 8'd0, 8'h00, 1'b0);
    compare_model(1'b1);

    // Randomized traffic with stalls that straddle the watchdog limit.
    do_reset();
    begin
      int stall = 0;
      for (int c = 0; c < 3000; c++) begin
        bit s, v;
        logic [7:0] l, d;
        s = ($urandom_range(0, 5) == 0);
        l = 8'($urandom_range(1, 12));
        d = 8'($urandom);
        if (stall > 0) begin
          v = 1'b0; stall--;
        end else begin
          v = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 30) == 0) stall = $urandom_range(TMO - 2, TMO + 2);
        end
        cyc(s, l, d, v);
        compare_model(1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
